ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 131 +++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter in front of a single-port word RAM.
// Every transaction walks IDLE -> ACCESS -> RESP -> IDLE. The RAM strobe
// and request fields are registered. Ready and rdata are decoded from the
// registered state, so the two-cycle latency is fixed.
//
//   state  | meaning
//   IDLE   | no transaction; arbitrate among valid masters
//   ACCESS | ram_en high for one cycle with latched addr/wdata/wstrb
//   RESP   | granted master sees ready and ram_rdata passed through
module ram_arbiter #(
  parameter int          ADDR_WIDTH = 13,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_valid,
  input  logic [31:0]           m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  input  logic [31:0]           m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_wstrb,
  input  logic [31:0]           ram_rdata,
  output logic [1:0]            grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] pick;
  logic [1:0] grant_q;
  logic       last_grant;  // 1: master 1 won the most recent arbitration

  // Only the word-address bits reach the RAM; the byte offset and upper bits
  // are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m0_addr[31:ADDR_WIDTH+2], m0_addr[1:0],
                              m1_addr[31:ADDR_WIDTH+2], m1_addr[1:0]};

  // Arbitration candidate: round-robin favours the master that did not win
  // last time; fixed priority always favours master 0 on a tie.
  always_comb begin
    pick = 2'b00;
    if (m0_valid && m1_valid) begin
      pick = ((FIXED_PRIO != 0) || last_grant) ? 2'b01 : 2'b10;
    end else if (m0_valid) begin
      pick = 2'b01;
    end else if (m1_valid) begin
      pick = 2'b10;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one accepted request forces the full three-state walk.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick != 2'b00) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered RAM request, grant and round-robin history.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= 2'b00;
      last_grant <= 1'b1;
      ram_en     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wstrb  <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (pick != 2'b00) begin
            grant_q    <= pick;
            last_grant <= pick[1];
            ram_en     <= 1'b1;
            ram_addr   <= pick[0] ? m0_addr[ADDR_WIDTH+1:2] : m1_addr[ADDR_WIDTH+1:2];
            ram_wdata  <= pick[0] ? m0_wdata : m1_wdata;
            ram_wstrb  <= pick[0] ? m0_wstrb : m1_wstrb;
          end
        end
        ACCESS: begin
          // Strobes drop with ram_en so no write can leak outside ACCESS.
          ram_en    <= 1'b0;
          ram_wstrb <= 4'b0000;
        end
        RESP: begin
          grant_q <= 2'b00;
        end
        default: begin
          grant_q   <= 2'b00;
          ram_en    <= 1'b0;
          ram_wstrb <= 4'b0000;
        end
      endcase
    end
  end

  // Master-side outputs: completion pulse and read-data pass-through in RESP.
  always_comb begin
    grant    = grant_q;
    m0_ready = (state == RESP) && grant_q[0];
    m1_ready = (state == RESP) && grant_q[1];
    m0_rdata = m0_ready ? ram_rdata : 32'h0;
    m1_rdata = m1_ready ? ram_rdata : 32'h0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: a round-robin and a fixed-priority instance
// share one set of stimulus. A directed vector table and a contention
// sequence come first, followed by random traffic checked against a
// transaction-level model.
module tb_ram_arbiter;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_valid, m1_valid;
  logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata, ram_rdata;
  logic [3:0]    m0_wstrb, m1_wstrb;

  logic          rr_m0_ready, rr_m1_ready, rr_ram_en;
  logic [31:0]   rr_m0_rdata, rr_m1_rdata, rr_ram_wdata;
  logic [AW-1:0] rr_ram_addr;
  logic [3:0]    rr_ram_wstrb;
  logic [1:0]    rr_grant;

  logic          fp_m0_ready, fp_m1_ready, fp_ram_en;
  logic [31:0]   fp_m0_rdata, fp_m1_rdata, fp_ram_wdata;
  logic [AW-1:0] fp_ram_addr;
  logic [3:0]    fp_ram_wstrb;
  logic [1:0]    fp_grant;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(0)) dut_rr (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(rr_m0_ready), .m0_rdata(rr_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(rr_m1_ready), .m1_rdata(rr_m1_rdata),
    .ram_en(rr_ram_en), .ram_addr(rr_ram_addr), .ram_wdata(rr_ram_wdata),
    .ram_wstrb(rr_ram_wstrb), .ram_rdata(ram_rdata), .grant(rr_grant));

  ram_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(fp_m0_ready), .m0_rdata(fp_m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(fp_m1_ready), .m1_rdata(fp_m1_rdata),
    .ram_en(fp_ram_en), .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata),
    .ram_wstrb(fp_ram_wstrb), .ram_rdata(ram_rdata), .grant(fp_grant));

  typedef struct {
    logic          en;
    logic [AW-1:0] addr;
    logic [31:0]   wd;
    logic [3:0]    ws;
    logic [1:0]    gnt;
    logic          r0, r1;
    logic [31:0]   rd0, rd1;
  } out_t;

  typedef struct {
    logic        rst, v0, v1;
    logic [31:0] a0, a1, wd0, wd1;
    logic [3:0]  s0, s1;
    logic [31:0] rr;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(string tag, out_t a, out_t e);
    check({tag, ".ram_en"},    32'(a.en),   32'(e.en));
    check({tag, ".ram_addr"},  32'(a.addr), 32'(e.addr));
    check({tag, ".ram_wdata"}, a.wd,        e.wd);
    check({tag, ".ram_wstrb"}, 32'(a.ws),   32'(e.ws));
    check({tag, ".grant"},     32'(a.gnt),  32'(e.gnt));
    check({tag, ".m0_ready"},  32'(a.r0),   32'(e.r0));
    check({tag, ".m1_ready"},  32'(a.r1),   32'(e.r1));
    check({tag, ".m0_rdata"},  a.rd0,       e.rd0);
    check({tag, ".m1_rdata"},  a.rd1,       e.rd1);
  endtask

  function automatic out_t get_out(int d);
    out_t o;
    if (d == 0) o = '{rr_ram_en, rr_ram_addr, rr_ram_wdata, rr_ram_wstrb, rr_grant,
                      rr_m0_ready, rr_m1_ready, rr_m0_rdata, rr_m1_rdata};
    else        o = '{fp_ram_en, fp_ram_addr, fp_ram_wdata, fp_ram_wstrb, fp_grant,
                      fp_m0_ready, fp_m1_ready, fp_m0_rdata, fp_m1_rdata};
    return o;
  endfunction

  task automatic add(logic r, logic v0, logic v1, logic [31:0] a0, logic [31:0] a1,
                     logic [31:0] wd0, logic [31:0] wd1, logic [3:0] s0, logic [3:0] s1,
                     logic [31:0] rr, logic en, logic [AW-1:0] addr, logic [31:0] wd,
                     logic [3:0] ws, logic [1:0] gnt, logic r0, logic r1,
                     logic [31:0] rd0, logic [31:0] rd1);
    vec_t v;
    v.rst = r; v.v0 = v0; v.v1 = v1; v.a0 = a0; v.a1 = a1;
    v.wd0 = wd0; v.wd1 = wd1; v.s0 = s0; v.s1 = s1; v.rr = rr;
    v.exp = '{en, addr, wd, ws, gnt, r0, r1, rd0, rd1};
    vecs.push_back(v);
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; m0_valid = v.v0; m1_valid = v.v1;
    m0_addr = v.a0; m1_addr = v.a1; m0_wdata = v.wd0; m1_wdata = v.wd1;
    m0_wstrb = v.s0; m1_wstrb = v.s1; ram_rdata = v.rr;
  endtask

  // Transaction-level model: each accepted request occupies the RAM for a
  // 2-cycle window (strobe cycle, then response cycle).
  int            busy[2];
  int            owner[2];
  int            last[2];
  logic [AW-1:0] maddr[2];
  logic [31:0]   mwd[2];
  logic [3:0]    mws[2];

  task automatic model_step();
    logic [31:0] a;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        busy[d] = 0; owner[d] = 0; last[d] = 1;
        maddr[d] = '0; mwd[d] = '0; mws[d] = '0;
      end else if (busy[d] > 0) begin
        busy[d]--;
      end else if (m0_valid || m1_valid) begin
        if (m0_valid && m1_valid) owner[d] = (d == 1) ? 0 : (last[d] == 1 ? 0 : 1);
        else                      owner[d] = m0_valid ? 0 : 1;
        last[d]  = owner[d];
        busy[d]  = 2;
        a        = (owner[d] == 0) ? m0_addr : m1_addr;
        maddr[d] = a[AW+1:2];
        mwd[d]   = (owner[d] == 0) ? m0_wdata : m1_wdata;
        mws[d]   = (owner[d] == 0) ? m0_wstrb : m1_wstrb;
      end
    end
  endtask

  function automatic out_t model_out(int d);
    out_t e = '{default: '0};
    e.addr = maddr[d];
    e.wd   = mwd[d];
    if (busy[d] == 2) begin
      e.en  = 1'b1;
      e.ws  = mws[d];
      e.gnt = (owner[d] == 0) ? 2'b01 : 2'b10;
    end else if (busy[d] == 1) begin
      e.gnt = (owner[d] == 0) ? 2'b01 : 2'b10;
      if (owner[d] == 0) begin e.r0 = 1'b1; e.rd0 = ram_rdata; end
      else               begin e.r1 = 1'b1; e.rd1 = ram_rdata; end
    end
    return e;
  endfunction

  logic [1:0] rr_gnts[$], fp_gnts[$];
  int         rr_cyc[$];

  initial begin
    //  rst v0 v1 a0 a1 wd0 wd1 s0 s1 rr | en addr wd ws gnt r0 r1 rd0 rd1
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 32'h0BAD0BAD,   1, 4, 0, 0, 2'b01, 0, 0, 0, 0);
    add(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 32'hDEADBEEF,   0, 4, 0, 0, 2'b01, 1, 0, 32'hDEADBEEF, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55,              0, 4, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h8, 0, 32'h12345678, 0, 4'b0011, 0,
        1, 2, 32'h12345678, 4'b0011, 2'b10, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h8, 0, 32'h12345678, 0, 4'b0011, 32'hA5A5A5A5,
        0, 2, 32'h12345678, 0, 2'b10, 0, 1, 0, 32'hA5A5A5A5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 2, 32'h12345678, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 32'h20, 32'h40, 32'h11, 32'h22, 0, 4'hF, 0,
        0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 32'h20, 32'h40, 32'h11, 32'h22, 0, 4'hF, 0,
        1, 8, 32'h11, 0, 2'b01, 0, 0, 0, 0);
    add(0, 1, 1, 32'h20, 32'h40, 32'h11, 32'h22, 0, 4'hF, 32'h1,
        0, 8, 32'h11, 0, 2'b01, 1, 0, 32'h1, 0);
    add(0, 0, 1, 32'h20, 32'h40, 32'h11, 32'h22, 0, 4'hF, 32'h9,
        0, 8, 32'h11, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 32'h20, 32'h40, 32'h11, 32'h22, 0, 4'hF, 0,
        1, 16, 32'h22, 4'hF, 2'b10, 0, 0, 0, 0);
    add(0, 0, 1, 32'h20, 32'h40, 32'h11, 32'h22, 0, 4'hF, 32'h2,
        0, 16, 32'h22, 0, 2'b10, 0, 1, 0, 32'h2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 16, 32'h22, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h4, 0, 0, 0, 0, 0, 0,               1, 1, 0, 0, 2'b01, 0, 0, 0, 0);
    add(1, 1, 0, 32'h4, 0, 0, 0, 0, 0, 32'h66,          0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 32'h4, 0, 0, 0, 0, 0, 0,               1, 1, 0, 0, 2'b01, 0, 0, 0, 0);
    add(0, 1, 0, 32'h4, 0, 0, 0, 0, 0, 32'h77,          0, 1, 0, 0, 2'b01, 1, 0, 32'h77, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                   0, 1, 0, 0, 0, 0, 0, 0, 0);

    drive(vecs[0]);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(posedge clk);
      @(negedge clk);
      check_out($sformatf("vec%0d.rr", i), get_out(0), vecs[i].exp);
      check_out($sformatf("vec%0d.fp", i), get_out(1), vecs[i].exp);
    end

    // Continuous contention: both masters keep valid high for 18 cycles.
    rst = 1'b1; m0_valid = 1'b0; m1_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; m0_valid = 1'b1; m1_valid = 1'b1;
    m0_wstrb = 4'h0; m1_wstrb = 4'h0;
    for (int c = 0; c < 18; c++) begin
      @(posedge clk); @(negedge clk);
      if (rr_ram_en) begin rr_gnts.push_back(rr_grant); rr_cyc.push_back(c); end
      if (fp_ram_en) fp_gnts.push_back(fp_grant);
    end
    check("contend.rr_pulses", rr_gnts.size(), 6);
    check("contend.fp_pulses", fp_gnts.size(), 6);
    for (int k = 0; k < rr_gnts.size(); k++)
      check($sformatf("contend.rr_grant%0d", k), 32'(rr_gnts[k]), (k % 2 == 0) ? 32'h1 : 32'h2);
    for (int k = 0; k < fp_gnts.size(); k++)
      check($sformatf("contend.fp_grant%0d", k), 32'(fp_gnts[k]), 32'h1);
    for (int k = 1; k < rr_cyc.size(); k++)
      check($sformatf("contend.spacing%0d", k), rr_cyc[k] - rr_cyc[k-1], 3);

    // Random traffic against the model; the first cycle resets both sides.
    for (int c = 0; c < 3000; c++) begin
      rst       = (c == 0) || ($urandom_range(0, 59) == 0);
      m0_valid  = ($urandom_range(0, 2) != 0);
      m1_valid  = ($urandom_range(0, 2) != 0);
      m0_addr   = $urandom;
      m1_addr   = $urandom;
      m0_wdata  = $urandom;
      m1_wdata  = $urandom;
      m0_wstrb  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      m1_wstrb  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      ram_rdata = $urandom;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_out($sformatf("rand%0d.rr", c), get_out(0), model_out(0));
      check_out($sformatf("rand%0d.fp", c), get_out(1), model_out(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
